// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Constants and types shared between the instruction fetch unit and the
// instruction ROM: the NOP encoding, default reset PC, default ROM size and
// the fetch state encoding, plus the PC legality check.
// ----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
    localparam int unsigned IFU_MEM_SIZE  = 1024;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // A PC is unusable when it is not word aligned or when the word it names
    // would extend past the last ROM byte. Compared unsigned at 32 bits.
    function automatic logic pc_is_bad(input logic [31:0] pc,
                                       input logic [31:0] last_pc);
        return (pc[1:0] != 2'b00) || (pc > last_pc);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_slot.sv
// ----------------------------------------------------------------------------
// fetch_slot
// Single-entry output register with a valid/ready handshake and a flush.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop the held entry; wins over load
//   load              : capture {load_pc, load_instr, load_fault}
//   load_pc/instr/fault : entry contents to capture
//   ready             : consumer accepts the held entry this cycle
//   valid, pc, instr, fault : the held entry
// The caller only asserts load when the slot is free (empty or being drained).
// ----------------------------------------------------------------------------
module fetch_slot #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        load_fault,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fault
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= RESET_INSTR;
            fault <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
            fault <= load_fault;
        end else if (ready) begin
            // Draining an empty slot is harmless, so no valid qualifier.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Holds the PC, drives the instruction ROM address and hands {pc, instr}
// entries to decode through a one-entry valid/ready slot. Misaligned or
// out-of-range PCs produce a faulting NOP entry and halt fetching until a
// redirect arrives.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : fetching permitted (0 freezes PC, no new capture)
//   rom_addr        : byte address to ROM (combinational, the current PC)
//   rom_instr       : ROM data for rom_addr
//   redirect_valid  : branch/jump taken, redirect_pc is the new PC
//   if_valid/if_ready : output handshake
//   if_pc, if_instr, if_fault : output entry
//   fetch_count     : number of accepted entries, wraps at 2^32
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter int unsigned MEM_SIZE  = IFU_MEM_SIZE,
    parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    logic [31:0]  pc_q;
    fetch_state_e state_q;
    logic         slot_free;
    logic         capture;
    logic         bad;
    logic         accept;
    logic [31:0]  capture_instr;

    assign rom_addr      = pc_q;
    assign accept        = if_valid & if_ready;
    assign slot_free     = !if_valid | if_ready;
    // A redirect suppresses capture: the ROM word belongs to the old path.
    assign capture       = !redirect_valid && (state_q == ST_RUN) && fetch_en && slot_free;
    assign bad           = pc_is_bad(pc_q, LAST_PC);
    assign capture_instr = bad ? NOP_INSTR : rom_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= ST_RUN;
        end else if (capture) begin
            if (bad) begin
                // PC stays on the faulting address for visibility.
                state_q <= ST_HALT;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    // Counts the handshake itself, so an entry accepted in a redirect cycle
    // is still counted even though the slot is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_slot #(
        .RESET_INSTR (NOP_INSTR)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .load       (capture),
        .load_pc    (pc_q),
        .load_instr (capture_instr),
        .load_fault (bad),
        .ready      (if_ready),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr),
        .fault      (if_fault)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit: a behavioural ROM, a per-cycle
// vector table with hand-computed expectations, a scoreboard queue of
// expected entries popped on every handshake, and hand-written sequences for
// the ROM-end fault/halt and asynchronous reset during a stall.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MSZ = 1024;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic [31:0] fetch_count;

    instr_fetch_unit #(
        .RESET_PC  (32'h0),
        .MEM_SIZE  (MSZ),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign rom_instr = rom_word(rom_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    typedef struct {
        bit          fe;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_fault;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    ent_t        exp_q[$];
    vec_t        vecs[24];
    int          n_pass;
    int          n_total;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_halt;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(bit fe, bit rdy, bit rv, logic [31:0] rpc, bit ev,
                                logic [31:0] epc, bit ef, logic [31:0] ea, logic [31:0] ec);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_fault = ef; v.e_addr = ea; v.e_cnt = ec;
        return v;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_count = 32'h0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, score the handshake happening at the
    // coming edge, advance the model, then sample 1 time unit after the edge.
    task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        ent_t e;
        bit   bad;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (m_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_valid", {31'h0, if_valid}, 32'd1);
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
                chk("sb_fault", {31'h0, if_fault}, {31'h0, e.fault});
            end
            m_count = m_count + 32'd1;
        end
        if (rv) begin
            if (m_valid && !rdy && exp_q.size() > 0) exp_q.delete(0);
            m_valid = 1'b0;
            m_pc    = rpc;
            m_halt  = 1'b0;
        end else if (!m_halt && fe && (!m_valid || rdy)) begin
            bad     = (m_pc[1:0] != 2'b00) || (m_pc > 32'(MSZ - 4));
            e.pc    = m_pc;
            e.instr = bad ? NOP : rom_word(m_pc);
            e.fault = bad;
            exp_q.push_back(e);
            m_valid = 1'b1;
            if (bad) m_halt = 1'b1;
            else     m_pc = m_pc + 32'd4;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("m_rom_addr", rom_addr, m_pc);
        chk("m_valid", {31'h0, if_valid}, {31'h0, m_valid});
        chk("m_count", fetch_count, m_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        //             fe rdy rv rpc       ev pc     f  addr    cnt
        vecs[0]  = mk(1, 1, 0, 32'h0,   1, 32'h0,  0, 32'h4,   0);
        vecs[1]  = mk(1, 1, 0, 32'h0,   1, 32'h4,  0, 32'h8,   1);
        vecs[2]  = mk(1, 1, 0, 32'h0,   1, 32'h8,  0, 32'hC,   2);
        vecs[3]  = mk(1, 0, 0, 32'h0,   1, 32'h8,  0, 32'hC,   2);
        vecs[4]  = mk(1, 0, 0, 32'h0,   1, 32'h8,  0, 32'hC,   2);
        vecs[5]  = mk(1, 0, 0, 32'h0,   1, 32'h8,  0, 32'hC,   2);
        vecs[6]  = mk(1, 0, 0, 32'h0,   1, 32'h8,  0, 32'hC,   2);
        vecs[7]  = mk(1, 1, 0, 32'h0,   1, 32'hC,  0, 32'h10,  3);
        vecs[8]  = mk(1, 0, 0, 32'h0,   1, 32'hC,  0, 32'h10,  3);
        vecs[9]  = mk(1, 0, 1, 32'h40,  0, 32'h0,  0, 32'h40,  3);
        vecs[10] = mk(1, 1, 0, 32'h0,   1, 32'h40, 0, 32'h44,  3);
        vecs[11] = mk(0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h44,  4);
        vecs[12] = mk(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h44,  4);
        vecs[13] = mk(1, 0, 0, 32'h0,   1, 32'h44, 0, 32'h48,  4);
        vecs[14] = mk(0, 0, 0, 32'h0,   1, 32'h44, 0, 32'h48,  4);
        vecs[15] = mk(0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h48,  5);
        vecs[16] = mk(1, 1, 1, 32'h42,  0, 32'h0,  0, 32'h42,  5);
        vecs[17] = mk(1, 0, 0, 32'h0,   1, 32'h42, 1, 32'h42,  5);
        vecs[18] = mk(1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h42,  6);
        vecs[19] = mk(1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h42,  6);
        vecs[20] = mk(1, 1, 1, 32'h10,  0, 32'h0,  0, 32'h10,  6);
        vecs[21] = mk(1, 1, 0, 32'h0,   1, 32'h10, 0, 32'h14,  6);
        vecs[22] = mk(1, 1, 0, 32'h0,   1, 32'h14, 0, 32'h18,  7);
        vecs[23] = mk(1, 1, 1, 32'h100, 0, 32'h0,  0, 32'h100, 8);

        #22;
        chk("rst_valid", {31'h0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_fault", {31'h0, if_fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_addr", i), rom_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_count", i), fetch_count, vecs[i].e_cnt);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), if_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_fault", i), {31'h0, if_fault}, {31'h0, vecs[i].e_fault});
                chk($sformatf("v%0d_instr", i), if_instr,
                    vecs[i].e_fault ? NOP : rom_word(vecs[i].e_pc));
            end
        end

        // Sequential run off the end of the ROM.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1, 1, 0, 32'h0);
            if (if_valid && if_pc == 32'd1024) found = 1'b1;
        end
        chk("end_reached", {31'h0, found}, 32'd1);
        chk("end_fault", {31'h0, if_fault}, 32'd1);
        chk("end_instr", if_instr, NOP);
        chk("end_addr", rom_addr, 32'd1024);
        step(1, 1, 0, 32'h0);
        chk("halt_drop", {31'h0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h0);
            chk("halt_idle", {31'h0, if_valid}, 32'd0);
            chk("halt_addr", rom_addr, 32'd1024);
        end

        // Asynchronous reset during a stall.
        step(1, 0, 1, 32'h20);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("stall_pc", if_pc, 32'h20);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, if_valid}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_addr", rom_addr, 32'h0);
        chk("arst_instr", if_instr, NOP);
        model_reset();
        #1;
        rst_n = 1'b1;
        step(1, 1, 0, 32'h0);
        chk("post_rst_pc", if_pc, 32'h0);
        chk("post_rst_instr", if_instr, rom_word(32'h0));
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("post_rst_pc2", if_pc, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
